// File: rtl/ddr_fifo_test_pkg.sv
// Shared constants and FSM state type for the DDR FIFO pattern generator
// and the downstream correctness checker.
package ddr_fifo_test_pkg;

    localparam int PATTERN_W = 48;
    localparam int CNT_LSB_W = 32;
    localparam int MIRROR_W  = 16;

    localparam logic [CNT_LSB_W-1:0] WRAP_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Reference pattern: counter in the low bits, its low half mirrored on top.
    function automatic logic [PATTERN_W-1:0] pattern_of(input logic [CNT_LSB_W-1:0] cnt);
        return {cnt[MIRROR_W-1:0], cnt};
    endfunction

endpackage

// File: rtl/ddr_fifo_pattern_gen_if.sv
// Word stream from the pattern generator to the DDR FIFO write side.
interface ddr_fifo_pattern_gen_if;
    import ddr_fifo_test_pkg::*;

    // A word moves on a clock edge where data_valid && data_ready. Once
    // data_valid is high, data and data_valid hold until that edge; only
    // reset may drop data_valid without a transfer.
    logic [PATTERN_W-1:0] data;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/pattern_word_fmt.sv
// Builds one 48-bit pattern word from the counter, optionally corrupting
// bit 0 so both the continuity and mirror checks downstream trip.
module pattern_word_fmt
    import ddr_fifo_test_pkg::*;
(
    input  logic [CNT_LSB_W-1:0] cnt,
    input  logic                 inject,
    output logic [PATTERN_W-1:0] word
);

    always_comb begin
        word    = pattern_of(cnt);
        word[0] = cnt[0] ^ inject;
    end

endmodule

// File: rtl/ddr_fifo_pattern_gen.sv
// Pattern generator top: run control FSM, counters, error injection and the
// valid/ready source towards the DDR FIFO.
module ddr_fifo_pattern_gen
    import ddr_fifo_test_pkg::*;
#(
    parameter int                   CNT_W      = 32,
    parameter logic [CNT_LSB_W-1:0] SEED       = 32'h0000_0000,
    parameter int unsigned          NUM_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  inject_err,
    ddr_fifo_pattern_gen_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      cycle_num,
    output state_t                fsm_state
);

    localparam logic [CNT_W-1:0] NUM_CYCLES_C = CNT_W'(NUM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t               state;
    logic [CNT_LSB_W-1:0] cnt;
    logic                 err_pend;

    logic                 transfer;
    logic                 wrap_hit;
    logic                 auto_done;
    logic                 load;
    logic [CNT_LSB_W-1:0] next_cnt;
    logic [CNT_W-1:0]     word_cnt_inc;
    logic [CNT_W-1:0]     cycle_num_inc;
    logic [CNT_W-1:0]     cycle_num_nxt;
    logic [PATTERN_W-1:0] next_word;

    assign transfer = bus.data_valid && bus.data_ready;

    // Wraps are counted on the counter, so an injected bit flip never
    // creates or hides a wrap.
    assign wrap_hit      = (cnt == WRAP_VALUE);
    assign word_cnt_inc  = (word_cnt == '1) ? word_cnt : word_cnt + CNT_ONE;
    assign cycle_num_inc = (cycle_num == '1) ? cycle_num : cycle_num + CNT_ONE;
    assign cycle_num_nxt = wrap_hit ? cycle_num_inc : cycle_num;

    assign auto_done = (state == RUN) && transfer && wrap_hit &&
                       (NUM_CYCLES_C != '0) && (cycle_num != '1) &&
                       (cycle_num_inc == NUM_CYCLES_C);

    // Stop and auto-stop both take priority over presenting a new word.
    assign load = (state == RUN) && !stop && !auto_done && !hold &&
                  (!bus.data_valid || transfer);

    assign next_cnt = transfer ? cnt + 32'd1 : cnt;

    pattern_word_fmt u_fmt (
        .cnt    (next_cnt),
        .inject (err_pend),
        .word   (next_word)
    );

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= SEED;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            word_cnt       <= '0;
            cycle_num      <= '0;
            err_pend       <= 1'b0;
        end else begin
            // A pulse landing on a load edge arms the word after this one.
            err_pend <= load ? inject_err : (err_pend | inject_err);

            if (load) begin
                bus.data       <= next_word;
                bus.data_valid <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cnt       <= SEED;
                        word_cnt  <= '0;
                        cycle_num <= '0;
                    end
                end

                RUN: begin
                    if (transfer) begin
                        cnt       <= next_cnt;
                        word_cnt  <= word_cnt_inc;
                        cycle_num <= cycle_num_nxt;
                    end
                    if (stop) begin
                        if (bus.data_valid && !bus.data_ready) begin
                            state <= STOPPING;
                        end else begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            bus.data_valid <= 1'b0;
                        end
                    end else if (auto_done) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        bus.data_valid <= 1'b0;
                    end else if (!load && transfer) begin
                        bus.data_valid <= 1'b0;
                    end
                end

                STOPPING: begin
                    if (transfer) begin
                        cnt            <= next_cnt;
                        word_cnt       <= word_cnt_inc;
                        cycle_num      <= cycle_num_nxt;
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.data_valid <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.data_valid && !bus.data_ready) |=> (bus.data_valid && $stable(bus.data))
    );

endmodule

// File: tb/tb_ddr_fifo_pattern_gen.sv
// Directed bench for ddr_fifo_pattern_gen: free run, stall, injection,
// stop/hold, async reset, and wrap with auto-stop on a second instance.
module tb_ddr_fifo_pattern_gen;
    import ddr_fifo_test_pkg::*;

    logic clk;
    logic rst_n;

    logic a_start, a_stop, a_hold, a_inject;
    logic a_busy, a_done;
    logic [31:0] a_word_cnt, a_cycle_num;
    state_t a_state;

    logic b_start, b_stop, b_hold, b_inject;
    logic b_busy, b_done;
    logic [31:0] b_word_cnt, b_cycle_num;
    state_t b_state;

    int checks = 0;
    int errors = 0;

    ddr_fifo_pattern_gen_if bus_a ();
    ddr_fifo_pattern_gen_if bus_b ();

    ddr_fifo_pattern_gen #(.CNT_W(32), .SEED(32'h0000_0000), .NUM_CYCLES(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (a_start),
        .stop       (a_stop),
        .hold       (a_hold),
        .inject_err (a_inject),
        .bus        (bus_a.master),
        .busy       (a_busy),
        .done       (a_done),
        .word_cnt   (a_word_cnt),
        .cycle_num  (a_cycle_num),
        .fsm_state  (a_state)
    );

    ddr_fifo_pattern_gen #(.CNT_W(32), .SEED(32'hFFFF_FFFD), .NUM_CYCLES(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .stop       (b_stop),
        .hold       (b_hold),
        .inject_err (b_inject),
        .bus        (bus_b.master),
        .busy       (b_busy),
        .done       (b_done),
        .word_cnt   (b_word_cnt),
        .cycle_num  (b_cycle_num),
        .fsm_state  (b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_word(input string tag, input logic [47:0] exp);
        check({tag, "_valid"}, 64'(bus_a.data_valid), 64'd1);
        check({tag, "_data"}, 64'(bus_a.data), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_stop = 0; a_hold = 0; a_inject = 0;
        b_start = 0; b_stop = 0; b_hold = 0; b_inject = 0;
        bus_a.data_ready = 1'b1;
        bus_b.data_ready = 1'b1;
        #12;
        check("rst_valid", 64'(bus_a.data_valid), 64'd0);
        check("rst_data", 64'(bus_a.data), 64'd0);
        check("rst_wcnt", 64'(a_word_cnt), 64'd0);
        check("rst_cyc", 64'(a_cycle_num), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_state", 64'(a_state), 64'(IDLE));
        rst_n = 1'b1;
        tick();

        // Free run at one word per cycle
        a_start = 1; tick(); a_start = 0;
        check("run_busy", 64'(a_busy), 64'd1);
        check("first_lat", 64'(bus_a.data_valid), 64'd0);
        tick(); check_word("w0", 48'h0000_0000_0000);
        tick(); check_word("w1", 48'h0001_0000_0001);
        check("wcnt1", 64'(a_word_cnt), 64'd1);
        tick(); check_word("w2", 48'h0002_0000_0002);
        tick(); check_word("w3", 48'h0003_0000_0003);
        check("wcnt3", 64'(a_word_cnt), 64'd3);

        // Start while running is ignored
        a_start = 1; tick(); a_start = 0;
        check_word("start_ign", 48'h0004_0000_0004);
        tick(3);
        check_word("w7", 48'h0007_0000_0007);

        // Back-pressure: word 7 held for 5 cycles
        bus_a.data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); check_word("stall7", 48'h0007_0000_0007);
        end
        bus_a.data_ready = 1'b1;
        tick(); check_word("w8", 48'h0008_0000_0008);
        check("wcnt8", 64'(a_word_cnt), 64'd8);

        // Error injection armed while word 0xF is stalled
        tick(7);
        bus_a.data_ready = 1'b0; a_inject = 1;
        tick(); a_inject = 0;
        check_word("inj_stalled", 48'h000F_0000_000F);
        bus_a.data_ready = 1'b1;
        tick(); check_word("inj_word", 48'h0010_0000_0011);
        tick(); check_word("inj_after", 48'h0011_0000_0011);
        check("wcnt11", 64'(a_word_cnt), 64'h11);

        // Stop with ready high: word transfers, straight to IDLE
        a_stop = 1; tick(); a_stop = 0;
        check("stop_state", 64'(a_state), 64'(IDLE));
        check("stop_valid", 64'(bus_a.data_valid), 64'd0);
        check("stop_busy", 64'(a_busy), 64'd0);
        check("stop_wcnt", 64'(a_word_cnt), 64'h12);

        // Restart, then hold with a pending word
        a_start = 1; tick(); a_start = 0;
        check("restart_wcnt", 64'(a_word_cnt), 64'd0);
        tick(); check_word("r0", 48'h0000_0000_0000);
        tick(2); check_word("r2", 48'h0002_0000_0002);
        a_hold = 1;
        tick();
        check("hold_valid", 64'(bus_a.data_valid), 64'd0);
        check("hold_wcnt", 64'(a_word_cnt), 64'd3);
        tick();
        check("hold_valid2", 64'(bus_a.data_valid), 64'd0);
        a_hold = 0;
        tick(); check_word("r3", 48'h0003_0000_0003);
        tick(2); check_word("r5", 48'h0005_0000_0005);

        // Stop while word 5 is stalled
        bus_a.data_ready = 1'b0; a_stop = 1;
        tick(); a_stop = 0;
        check("stp_state", 64'(a_state), 64'(STOPPING));
        check("stp_busy", 64'(a_busy), 64'd1);
        check_word("stp_w5", 48'h0005_0000_0005);
        tick();
        check("stp_state2", 64'(a_state), 64'(STOPPING));
        bus_a.data_ready = 1'b1;
        tick();
        check("stp_idle", 64'(a_state), 64'(IDLE));
        check("stp_valid", 64'(bus_a.data_valid), 64'd0);
        check("stp_wcnt", 64'(a_word_cnt), 64'd6);
        tick();
        check("stp_no_w6", 64'(bus_a.data_valid), 64'd0);
        check("stp_wcnt2", 64'(a_word_cnt), 64'd6);

        // Async reset between edges
        a_start = 1; tick(); a_start = 0;
        tick(3);
        check_word("pre_rst", 48'h0002_0000_0002);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus_a.data_valid), 64'd0);
        check("arst_wcnt", 64'(a_word_cnt), 64'd0);
        check("arst_cyc", 64'(a_cycle_num), 64'd0);
        check("arst_busy", 64'(a_busy), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        a_start = 1; tick(); a_start = 0;
        tick(); check_word("arst_seed", 48'h0000_0000_0000);

        // Wrap and auto-stop on the second instance
        b_start = 1; tick(); b_start = 0;
        tick();
        check("b_fffd", 64'(bus_b.data), 64'hFFFD_FFFF_FFFD);
        tick();
        check("b_fffe", 64'(bus_b.data), 64'hFFFE_FFFF_FFFE);
        tick();
        check("b_ffff", 64'(bus_b.data), 64'hFFFF_FFFF_FFFF);
        check("b_cyc0", 64'(b_cycle_num), 64'd0);
        tick();
        check("b_cyc1", 64'(b_cycle_num), 64'd1);
        check("b_done", 64'(b_done), 64'd1);
        check("b_state", 64'(b_state), 64'(DONE));
        check("b_valid_off", 64'(bus_b.data_valid), 64'd0);
        check("b_wcnt", 64'(b_word_cnt), 64'd3);
        tick();
        check("b_no_zero", 64'(bus_b.data_valid), 64'd0);
        b_start = 1; tick(); b_start = 0;
        check("b_rerun", 64'(b_state), 64'(RUN));
        check("b_rerun_done", 64'(b_done), 64'd0);
        check("b_rerun_cyc", 64'(b_cycle_num), 64'd0);
        tick();
        check("b_rerun_w", 64'(bus_b.data), 64'hFFFD_FFFF_FFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_fifo_pattern_gen.md
Name: ddr_fifo_pattern_gen

Overview:
- Stimulus source for the DDR FIFO data path; drives the FIFO write side with the 48-bit self-checking pattern the downstream correctness checker expects.
- Pattern per word: low 32 bits are an incrementing counter, and bits [47:32] mirror the counter's low 16 bits.
- Valid/ready handshake with back-pressure, start/stop control, wrap ("cycle") counting with optional auto-stop, and single-word error injection for checker self-test.

Parameters:
- SEED, 32'h0000_0000, first counter value after each start.
- NUM_CYCLES, 0, number of counter wraps before auto-stop; 0 = run until stop.
- CNT_W, 32, width of the word_cnt and cycle_num counters.

Ports:
- clk  input  1  single clock for all logic
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- stop  input  1  one-cycle pulse; graceful stop
- hold  input  1  throttle; suppresses new words while high
- inject_err  input  1  one-cycle pulse; corrupt the next fresh word
- data_ready  input  1  FIFO can accept a word
- data  output  48  {cnt[15:0], cnt[31:0]}, possibly with injected error
- data_valid  output  1  data is valid
- busy  output  1  FSM is in RUN or STOPPING
- done  output  1  FSM is in DONE
- word_cnt  output  CNT_W  accepted words this run
- cycle_num  output  CNT_W  accepted words whose low 32 bits equal 32'hFFFF_FFFF

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM = IDLE; cnt = SEED; data = 0; data_valid = 0; busy = 0; done = 0; word_cnt = 0; cycle_num = 0; err_pend = 0.
- Handshake:
  - A transfer occurs on a clock edge where data_valid && data_ready.
  - While data_valid=1 and data_ready=0, data and data_valid hold stable.
  - data_valid never drops without a transfer, except on reset.
- FSM states: IDLE, RUN, STOPPING, DONE.
  - IDLE --start--> RUN: cnt=SEED, word_cnt=0, cycle_num=0.
  - RUN: if hold=0 and no word is pending (or a transfer occurs this edge), present the next word. First word appears 1 cycle after start. With data_ready tied high, throughput is 1 word/cycle.
  - RUN --stop--> STOPPING if a word is pending. Otherwise RUN --stop--> IDLE.
  - STOPPING: no new words; the pending word completes its transfer, then the FSM goes to IDLE.
  - RUN --(NUM_CYCLES!=0 && transfer increments cycle_num to NUM_CYCLES)--> DONE. data_valid deasserts on the following cycle.
  - DONE --start--> RUN, same initialisation as from IDLE.
  - start while in RUN or STOPPING: ignored.
  - start and stop in the same cycle: stop wins in RUN; start wins in IDLE/DONE.
- Counter:
  - On each transfer, cnt <= cnt+1 mod 2^32 (32'hFFFF_FFFF wraps to 0) and word_cnt += 1.
  - If the transferred word's low 32 bits = 32'hFFFF_FFFF, cycle_num += 1.
  - Both word_cnt and cycle_num saturate at all-ones.
- Error injection:
  - inject_err sets err_pend.
  - The next freshly loaded word has data[0] inverted; err_pend clears at load.
  - Injection is not applied to a word already stalled.
  - cnt is unaffected, so the following word is correct again.
  - The corrupted word breaks both the +1 continuity check and the [47:32]==[15:0] check.
- hold=1 with a pending word: the word stays valid until transferred, then no new word is loaded.
- Reset mid-run: everything returns to reset values immediately; any in-flight word is abandoned.

Decomposition:
- Shared package ddr_fifo_test_pkg: FSM state typedef (IDLE/RUN/STOPPING/DONE), PATTERN_W=48, CNT_LSB_W=32, MIRROR_W=16, WRAP_VALUE=32'hFFFF_FFFF. The checker uses the same constants.
- Sub-module pattern_word_fmt: combinational; takes cnt and inject flag and produces the 48-bit word. All other logic stays in the top module.

Test Plan:
- Free run: SEED=0, data_ready=1, start. Words 0x0000_0000_0000, 0x0001_0000_0001, 0x0002_0000_0002 on consecutive cycles; word_cnt=3 after 3 transfers.
- Back-pressure: drop data_ready for 5 cycles while word 0x0007_0000_0007 is valid. data stays 0x0007_0000_0007 for all 5 cycles; next word after ready returns is 0x0008_0000_0008; no word is skipped.
- Wrap and auto-stop: SEED=32'hFFFF_FFFD, NUM_CYCLES=1. Transfers FFFD, FFFE, FFFF; cycle_num=1; done=1; data_valid=0 the next cycle; no word 0x0000_0000_0000 is sent.
- Error injection: pulse inject_err before word 0x0010_0000_0010. Transferred word is 0x0010_0000_0011; following word is 0x0011_0000_0011.
- Stop with stall: stop pulse while word 5 is valid and ready=0. busy stays 1 and the state is STOPPING; after ready, word 5 transfers, FSM goes to IDLE, no word 6 is sent.
- Async reset mid-run: rst_n low between clock edges. data_valid, word_cnt and cycle_num go to 0 without waiting for a clock edge; the next start restarts at SEED.
